gpio_bank: RTL

Parametrised GPIO bank with per-pin direction, output, synchronised and debounced inputs, and edge-triggered interrupts. Register access uses a single-outstanding req/ack bus. It replaces the fixed 8-bit direction/value GPIO pair on the core wrapper. The testbench can instantiate it with any pin count and drive its inputs, including loopback of its own outputs.

---
 rtl/gpio_bank_if.sv | 12 +
 rtl/gpio_bank.sv | 126 ++++++++++++
 2 files changed

// File: rtl/gpio_bank_if.sv
// Register bus for gpio_bank: single-outstanding req/ack handshake with 3-bit word address.
interface gpio_bank_if;
  logic        req_i;
  logic        we_i;
  logic [2:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;

  modport master (output req_i, we_i, addr_i, wdata_i, input rdata_o, ack_o);
  modport slave  (input req_i, we_i, addr_i, wdata_i, output rdata_o, ack_o);
endinterface

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: direction/output registers, synchronised and debounced
// inputs, rise/fall edge interrupts with write-1-to-clear pending bits.
module gpio_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEB_W = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  gpio_bank_if.slave       bus,
  output logic [WIDTH-1:0] gpio_dir_o,
  output logic [WIDTH-1:0] gpio_val_o,
  input  logic [WIDTH-1:0] gpio_val_i,
  output logic             irq_o
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dir_q, out_q, rise_en_q, fall_en_q, pend_q;
  logic [WIDTH-1:0] sync1_q, sync2_q, stable_q;
  logic [WIDTH-1:0] hit, set_pend, clr_pend;
  logic [DEB_W-1:0] thr_q, thr_eff;
  logic [DEB_W-1:0] cnt_q [WIDTH];
  logic [31:0]      rd_mux, rdata_q;
  logic             ack_q, irq_q;

  assign thr_eff = (thr_q == '0) ? DEB_W'(1) : thr_q;

  // Widened compare so a threshold lowered below the running count still fires.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      hit[i] = (sync2_q[i] != stable_q[i]) &&
               (({1'b0, cnt_q[i]} + {{DEB_W{1'b0}}, 1'b1}) >= {1'b0, thr_eff});
    end
  end

  assign set_pend = hit & ((sync2_q & rise_en_q) | (~sync2_q & fall_en_q));

  always_comb begin
    clr_pend = '0;
    if (state_q == S_IDLE && bus.req_i && bus.we_i && bus.addr_i == 3'd5)
      clr_pend = bus.wdata_i[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr_i)
      3'd0:    rd_mux[WIDTH-1:0] = dir_q;
      3'd1:    rd_mux[WIDTH-1:0] = out_q;
      3'd2:    rd_mux[WIDTH-1:0] = stable_q;
      3'd3:    rd_mux[WIDTH-1:0] = rise_en_q;
      3'd4:    rd_mux[WIDTH-1:0] = fall_en_q;
      3'd5:    rd_mux[WIDTH-1:0] = pend_q;
      3'd6:    rd_mux[DEB_W-1:0] = thr_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= gpio_val_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_q ^ hit;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == stable_q[i] || hit[i]) cnt_q[i] <= '0;
        else                                     cnt_q[i] <= cnt_q[i] + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      thr_q     <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      // New edge events take priority over a same-cycle clear.
      pend_q  <= (pend_q & ~clr_pend) | set_pend;
      irq_q   <= |pend_q;
      case (state_q)
        S_IDLE: begin
          if (bus.req_i) begin
            ack_q   <= 1'b1;
            state_q <= S_ACK;
            if (bus.we_i) begin
              case (bus.addr_i)
                3'd0:    dir_q     <= bus.wdata_i[WIDTH-1:0];
                3'd1:    out_q     <= bus.wdata_i[WIDTH-1:0];
                3'd3:    rise_en_q <= bus.wdata_i[WIDTH-1:0];
                3'd4:    fall_en_q <= bus.wdata_i[WIDTH-1:0];
                3'd6:    thr_q     <= bus.wdata_i[DEB_W-1:0];
                default: ;
              endcase
            end else begin
              rdata_q <= rd_mux;
            end
          end
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.rdata_o = rdata_q;
  assign gpio_dir_o  = dir_q;
  assign gpio_val_o  = out_q;
  assign irq_o       = irq_q;

endmodule
